am_lock_fsm: RTL

- Receive-side alignment-marker (AM) lock machine for one PCS lane; the counterpart of the TX AM-insertion period counter.
- Watches per-block AM-match flags from the lane comparator, predicts where the next AM must arrive, and acquires and loses AM lock per the Clause 82 style rules.
- Sits after block lock and before lane deskew/reorder. Drives AM lock status and an expected-AM-slot strobe used for AM removal.

---
 rtl/am_lock_fsm.sv | 133 +++++++++++++
 1 files changed

// File: rtl/am_lock_fsm.sv
// Receive-side alignment-marker lock machine for one PCS lane: predicts the
// next AM position from a period counter and acquires/loses AM lock.
module am_lock_fsm #(
   parameter int AM_PERIOD         = 16384,
   parameter int NB_AM_PERIOD      = $clog2(AM_PERIOD),
   parameter int VALID_TO_LOCK     = 2,
   parameter int INVALID_TO_UNLOCK = 4,
   parameter int NB_INVALID        = $clog2(INVALID_TO_UNLOCK+1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   input  logic                    i_block_lock,
   input  logic                    i_am_match,
   output logic                    o_am_lock,
   output logic                    o_am_slot,
   output logic                    o_resync,
   output logic [NB_INVALID-1:0]   o_invalid_count,
   output logic [NB_AM_PERIOD-1:0] o_counter
);

   localparam int NB_GOOD = $clog2(VALID_TO_LOCK+1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [NB_AM_PERIOD-1:0] counter_q, counter_d;
   logic [NB_GOOD-1:0]      good_cnt_q, good_cnt_d;
   logic [NB_INVALID-1:0]   invalid_cnt_q, invalid_cnt_d;
   logic                    am_lock_q, am_lock_d;
   logic                    resync_q, resync_d;
   logic                    check;
   logic [NB_GOOD-1:0]      good_inc;
   logic [NB_INVALID-1:0]   invalid_inc;

   assign check       = i_valid && (state_q != SEARCH) &&
                        (counter_q == NB_AM_PERIOD'(AM_PERIOD-1));
   assign good_inc    = good_cnt_q + NB_GOOD'(1);
   assign invalid_inc = invalid_cnt_q + NB_INVALID'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= SEARCH;
         counter_q     <= '0;
         good_cnt_q    <= '0;
         invalid_cnt_q <= '0;
         am_lock_q     <= 1'b0;
         resync_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         counter_q     <= counter_d;
         good_cnt_q    <= good_cnt_d;
         invalid_cnt_q <= invalid_cnt_d;
         am_lock_q     <= am_lock_d;
         resync_q      <= resync_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      counter_d     = counter_q;
      good_cnt_d    = good_cnt_q;
      invalid_cnt_d = invalid_cnt_q;
      resync_d      = 1'b0;

      if (!i_block_lock) begin
         state_d       = SEARCH;
         counter_d     = '0;
         good_cnt_d    = '0;
         invalid_cnt_d = '0;
         resync_d      = (state_q != SEARCH);
      end else if (i_valid) begin
         // The slot block restarts the period regardless of its verdict.
         counter_d = check ? '0 : counter_q + NB_AM_PERIOD'(1);
         case (state_q)
            SEARCH: begin
               counter_d = '0;
               if (i_am_match) begin
                  state_d    = CHECK;
                  good_cnt_d = NB_GOOD'(1);
               end
            end
            CHECK: begin
               if (check) begin
                  if (i_am_match) begin
                     if (good_inc == NB_GOOD'(VALID_TO_LOCK)) begin
                        state_d       = LOCKED;
                        good_cnt_d    = '0;
                        invalid_cnt_d = '0;
                     end else begin
                        good_cnt_d = good_inc;
                     end
                  end else begin
                     state_d    = SEARCH;
                     good_cnt_d = '0;
                     resync_d   = 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (check) begin
                  if (i_am_match) begin
                     invalid_cnt_d = '0;
                  end else if (invalid_inc == NB_INVALID'(INVALID_TO_UNLOCK)) begin
                     state_d       = SEARCH;
                     invalid_cnt_d = '0;
                     resync_d      = 1'b1;
                  end else begin
                     invalid_cnt_d = invalid_inc;
                  end
               end
            end
            default: begin
               state_d   = SEARCH;
               counter_d = '0;
            end
         endcase
      end

      am_lock_d = (state_d == LOCKED);
   end

   assign o_am_lock       = am_lock_q;
   assign o_am_slot       = check;
   assign o_resync        = resync_q;
   assign o_invalid_count = invalid_cnt_q;
   assign o_counter       = counter_q;

endmodule
